pipeline_scoreboard: RTL and testbench

Parametrised hazard tracker for the pipelined core. It replaces fixed EX/MEM/WB compare-and-stall logic with a shift-register scoreboard of in-flight register writes, with configurable issue-to-writeback latency and an optional forwarding mode. It sits beside the ID stage, emits stall and per-source forward selects, and keeps a saturating stall counter for performance analysis.

---
 rtl/pipeline_scoreboard_pkg.sv | 27 ++
 rtl/pipeline_scoreboard_match.sv | 37 +++
 rtl/pipeline_scoreboard.sv | 115 +++++++++++
 tb/tb_pipeline_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_scoreboard_pkg.sv
// Purpose : shared types and constants for the in-flight register-write scoreboard.
// Latency : n/a (types and constants only).
// Backpress: n/a.
// Contents: sb_entry_t, pipeline stage indices, forward-select encoding.
package pipeline_pkg;

  // Widest register index an entry can hold; narrower indices are zero-extended,
  // so the unused upper bits are constant and drop out in synthesis.
  localparam int RD_W_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  // Classic stage numbering; scoreboard entry 0 corresponds to PL_EX.
  localparam int PL_IF  = 0;
  localparam int PL_ID  = 1;
  localparam int PL_EX  = 2;
  localparam int PL_MEM = 3;
  localparam int PL_WB  = 4;

  // Forward select meaning "read the register file".
  localparam int FWD_SEL_REGFILE = 0;

endpackage

// File: rtl/pipeline_scoreboard_match.sv
// Purpose : youngest-first priority match of one source register against the scoreboard.
// Latency : combinational.
// Backpress: none; pure lookup.
// Ports   : i entries (packed entry array), addr, used; o hit, index, is_load.
module scoreboard_match
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LATENCY        = 3,
  parameter int IDX_W          = $clog2(LATENCY)
) (
  input  sb_entry_t [LATENCY-1:0]      entries,
  input  logic [REG_ADDR_WIDTH-1:0]    addr,
  input  logic                         used,
  output logic                         hit,
  output logic [IDX_W-1:0]             index,
  output logic                         is_load
);

  logic [RD_W_MAX-1:0] w_addr_ext;
  assign w_addr_ext = RD_W_MAX'(addr);

  always_comb begin
    hit     = 1'b0;
    index   = '0;
    is_load = 1'b0;
    // Walk oldest to youngest so the lowest matching index overwrites the rest.
    for (int k = LATENCY - 1; k >= 0; k--) begin
      if (used && (addr != '0) && entries[k].valid && (entries[k].rd == w_addr_ext)) begin
        hit     = 1'b1;
        index   = IDX_W'(k);
        is_load = entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Purpose : shift-register scoreboard of in-flight register writes; emits stall and forward selects.
// Latency : stall/fwd selects are combinational from inputs; state advances one entry per clock.
// Backpress: stall holds IF/ID and injects a bubble; flush overrides stall and squashes entry 0.
// Ports   : clock, reset (async, active-high); issue_* describe the ID instruction; rs1/rs2 sources;
//           flush; outputs stall, fwd_rs1_sel, fwd_rs2_sel, stall_count (saturating).
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int LATENCY         = 3,
  parameter int FORWARD_EN      = 0,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]       issue_rd,
  input  logic                            issue_rd_write,
  input  logic                            issue_is_load,
  input  logic [REG_ADDR_WIDTH-1:0]       rs1_addr,
  input  logic                            rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0]       rs2_addr,
  input  logic                            rs2_used,
  input  logic                            flush,
  output logic                            stall,
  output logic [$clog2(LATENCY+1)-1:0]    fwd_rs1_sel,
  output logic [$clog2(LATENCY+1)-1:0]    fwd_rs2_sel,
  output logic [STALL_CNT_WIDTH-1:0]      stall_count
);

  localparam int IDX_W = $clog2(LATENCY);
  localparam int SEL_W = $clog2(LATENCY + 1);

  sb_entry_t [LATENCY-1:0]     r_entries;
  logic [STALL_CNT_WIDTH-1:0]  r_stall_count;

  logic                        w_m1_hit, w_m1_ld, w_m2_hit, w_m2_ld;
  logic [IDX_W-1:0]            w_m1_idx, w_m2_idx;
  logic                        w_st1, w_st2;
  logic [SEL_W-1:0]            w_sel1, w_sel2;
  logic                        w_issue;

  scoreboard_match #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .LATENCY        (LATENCY)
  ) u_match_rs1 (
    .entries (r_entries),
    .addr    (rs1_addr),
    .used    (rs1_used),
    .hit     (w_m1_hit),
    .index   (w_m1_idx),
    .is_load (w_m1_ld)
  );

  scoreboard_match #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .LATENCY        (LATENCY)
  ) u_match_rs2 (
    .entries (r_entries),
    .addr    (rs2_addr),
    .used    (rs2_used),
    .hit     (w_m2_hit),
    .index   (w_m2_idx),
    .is_load (w_m2_ld)
  );

  // Only a load still in EX cannot be forwarded; anything older has its data on a bypass path.
  always_comb begin
    w_st1  = 1'b0;
    w_st2  = 1'b0;
    w_sel1 = SEL_W'(FWD_SEL_REGFILE);
    w_sel2 = SEL_W'(FWD_SEL_REGFILE);
    if (w_m1_hit) begin
      if (FORWARD_EN == 0)                   w_st1  = 1'b1;
      else if ((w_m1_idx == '0) && w_m1_ld)  w_st1  = 1'b1;
      else                                   w_sel1 = SEL_W'(w_m1_idx) + SEL_W'(1);
    end
    if (w_m2_hit) begin
      if (FORWARD_EN == 0)                   w_st2  = 1'b1;
      else if ((w_m2_idx == '0) && w_m2_ld)  w_st2  = 1'b1;
      else                                   w_sel2 = SEL_W'(w_m2_idx) + SEL_W'(1);
    end
  end

  assign stall       = issue_valid && (w_st1 || w_st2);
  assign fwd_rs1_sel = w_sel1;
  assign fwd_rs2_sel = w_sel2;
  assign stall_count = r_stall_count;

  // Writes to x0 are never tracked, so x0 can never create a hazard.
  assign w_issue = issue_valid && !stall && !flush && issue_rd_write && (issue_rd != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_entries     <= '0;
      r_stall_count <= '0;
    end else begin
      for (int k = LATENCY - 1; k >= 2; k--) begin
        r_entries[k] <= r_entries[k-1];
      end
      // A flush squashes the instruction that was in EX as it moves on.
      r_entries[1]       <= r_entries[0];
      r_entries[1].valid <= r_entries[0].valid && !flush;

      r_entries[0].valid   <= w_issue;
      r_entries[0].rd      <= w_issue ? RD_W_MAX'(issue_rd) : '0;
      r_entries[0].is_load <= w_issue && issue_is_load;

      if (stall && !flush && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
module tb_pipeline_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic       issue_rd_write = 1'b0;
  logic       issue_is_load = 1'b0;
  logic [4:0] rs1_addr = '0;
  logic       rs1_used = 1'b0;
  logic [4:0] rs2_addr = '0;
  logic       rs2_used = 1'b0;
  logic       flush = 1'b0;

  logic        st0, st1, st2;
  logic [1:0]  a1_0, a2_0, a1_1, a2_1, a1_2, a2_2;
  logic [31:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // dut0: stall-only; dut1: forwarding; dut2: stall-only with a 2-bit counter.
  pipeline_scoreboard #(.REG_ADDR_WIDTH(5), .LATENCY(3), .FORWARD_EN(0), .STALL_CNT_WIDTH(32)) u_dut0 (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_write(issue_rd_write), .issue_is_load(issue_is_load),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .flush(flush), .stall(st0), .fwd_rs1_sel(a1_0), .fwd_rs2_sel(a2_0), .stall_count(cnt0));

  pipeline_scoreboard #(.REG_ADDR_WIDTH(5), .LATENCY(3), .FORWARD_EN(1), .STALL_CNT_WIDTH(32)) u_dut1 (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_write(issue_rd_write), .issue_is_load(issue_is_load),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .flush(flush), .stall(st1), .fwd_rs1_sel(a1_1), .fwd_rs2_sel(a2_1), .stall_count(cnt1));

  pipeline_scoreboard #(.REG_ADDR_WIDTH(5), .LATENCY(3), .FORWARD_EN(0), .STALL_CNT_WIDTH(2)) u_dut2 (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_write(issue_rd_write), .issue_is_load(issue_is_load),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .flush(flush), .stall(st2), .fwd_rs1_sel(a1_2), .fwd_rs2_sel(a2_2), .stall_count(cnt2));

  typedef struct {
    int dut; int rst;
    int iv; int ird; int iwr; int ild;
    int r1; int u1; int r2; int u2; int fl;
    int es; int e1; int e2; int ec;
  } row_t;

  row_t tbl[$];

  function automatic void add(int dut, int rst, int iv, int ird, int iwr, int ild,
                              int r1, int u1, int r2, int u2, int fl,
                              int es, int e1, int e2, int ec);
    row_t r;
    r.dut = dut; r.rst = rst; r.iv = iv; r.ird = ird; r.iwr = iwr; r.ild = ild;
    r.r1 = r1; r.u1 = u1; r.r2 = r2; r.u2 = u2; r.fl = fl;
    r.es = es; r.e1 = e1; r.e2 = e2; r.ec = ec;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample(input int d, output int s, output int f1, output int f2, output int c);
    case (d)
      0:       begin s = int'(st0); f1 = int'(a1_0); f2 = int'(a2_0); c = int'(cnt0); end
      1:       begin s = int'(st1); f1 = int'(a1_1); f2 = int'(a2_1); c = int'(cnt1); end
      default: begin s = int'(st2); f1 = int'(a1_2); f2 = int'(a2_2); c = int'(cnt2); end
    endcase
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_rd_write = 0; issue_is_load = 0;
    rs1_addr = 0; rs1_used = 0; rs2_addr = 0; rs2_used = 0; flush = 0;
  endtask

  // Leaves reset released just after a falling edge.
  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  task automatic drive(input int iv, input int ird, input int iwr, input int ild,
                       input int r1, input int u1, input int r2, input int u2, input int fl);
    issue_valid = iv[0]; issue_rd = ird[4:0]; issue_rd_write = iwr[0]; issue_is_load = ild[0];
    rs1_addr = r1[4:0]; rs1_used = u1[0]; rs2_addr = r2[4:0]; rs2_used = u2[0]; flush = fl[0];
  endtask

  initial begin
    int s, f1, f2, c;

    // Test 1: stall-only, consumer of x5 waits out the full latency.
    add(0,1, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(0,0, 1,0,0,0, 5,1,0,0,0, 1,0,0,0);
    add(0,0, 1,0,0,0, 5,1,0,0,0, 1,0,0,1);
    add(0,0, 1,0,0,0, 5,1,0,0,0, 1,0,0,2);
    add(0,0, 1,0,0,0, 5,1,0,0,0, 0,0,0,3);
    // Test 2: forwarding from an ALU producer, including the oldest entry and retirement.
    add(1,1, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,0,0,0, 0,0,5,1,0, 0,0,1,0);
    add(1,1, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,3,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,0,0,0, 0,0,5,1,0, 0,0,2,0);
    add(1,0, 1,0,0,0, 0,0,5,1,0, 0,0,3,0);
    add(1,0, 1,0,0,0, 0,0,5,1,0, 0,0,0,0);
    // Test 3: load-use stalls one cycle, then forwards from entry 1.
    add(1,1, 1,7,1,1, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,0,0,0, 7,1,0,0,0, 1,0,0,0);
    add(1,0, 1,0,0,0, 7,1,0,0,0, 0,2,0,1);
    // Test 4: x0 never matches; unused sources never match.
    add(1,1, 1,0,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,9,1,0, 0,1,0,0,0, 0,0,0,0);
    add(1,0, 1,0,0,0, 0,0,9,0,0, 0,0,0,0);
    add(0,1, 1,9,1,0, 0,0,0,0,0, 0,0,0,0);
    add(0,0, 1,0,0,0, 0,1,9,0,0, 0,0,0,0);
    // Test 5: flush squashes entry 0 and the issuing x6; no stall counted.
    add(0,1, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(0,0, 1,6,1,0, 5,1,0,0,1, 1,0,0,0);
    add(0,0, 1,0,0,0, 5,1,6,1,0, 0,0,0,0);
    add(1,1, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,6,1,0, 5,1,0,0,1, 0,1,0,0);
    add(1,0, 1,0,0,0, 5,1,6,1,0, 0,0,0,0);
    // Test 6: two x5 producers at entries 0 and 2, youngest wins.
    add(1,1, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,3,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,5,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0, 1,0,0,0, 5,1,0,0,0, 0,1,0,0);

    // Reset state, with inputs that would otherwise provoke a hazard.
    drive(1,5,1,1, 5,1,5,1,0);
    #2 reset = 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d, s, f1, f2, c);
      chk($sformatf("reset dut%0d stall", d), s, 0);
      chk($sformatf("reset dut%0d sel1", d), f1, 0);
      chk($sformatf("reset dut%0d sel2", d), f2, 0);
      chk($sformatf("reset dut%0d count", d), c, 0);
    end
    @(negedge clock);

    foreach (tbl[i]) begin
      if (tbl[i].rst != 0) do_reset();
      drive(tbl[i].iv, tbl[i].ird, tbl[i].iwr, tbl[i].ild,
            tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2, tbl[i].fl);
      #1;
      sample(tbl[i].dut, s, f1, f2, c);
      chk($sformatf("row%0d stall", i), s, tbl[i].es);
      chk($sformatf("row%0d sel1", i), f1, tbl[i].e1);
      chk($sformatf("row%0d sel2", i), f2, tbl[i].e2);
      chk($sformatf("row%0d count", i), c, tbl[i].ec);
      @(negedge clock);
    end

    // Saturation on the 2-bit counter, then asynchronous reset in the middle of a stall.
    do_reset();
    drive(1,5,1,0, 0,0,0,0,0);
    @(negedge clock);
    drive(1,6,1,0, 5,1,0,0,0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sat x5 stall c%0d", k), int'(st2), 1);
      @(negedge clock);
    end
    #1;
    chk("sat x6 issue stall", int'(st2), 0);
    chk("sat count before x6", int'(cnt2), 3);
    @(negedge clock);
    drive(1,0,0,0, 6,1,0,0,0);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("sat stall still on", int'(st2), 1);
    chk("sat count held", int'(cnt2), 3);
    chk("sat wide count", int'(cnt0), 5);
    reset = 1;
    #1;
    chk("async reset stall", int'(st2), 0);
    chk("async reset count", int'(cnt2), 0);
    chk("async reset wide count", int'(cnt0), 0);
    @(negedge clock);
    reset = 0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
